yc_fsm: RTL and testbench
=========================

YC_FSM -- requirements
Module: yc_fsm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 in  input  2  dual-rail input token: 00 empty, 01 logic 0, 10 logic 1, 11 illegal.
REQ-006 match  input  2  dual-rail match token, same encoding as in.
REQ-007 out  output  2  dual-rail result token, same encoding as in; driven directly from registers.

Function
REQ-008 A token is valid only if it is 01 or 10; 00 and 11 SHALL be treated as not valid.
REQ-009 The block SHALL hold two 2-bit latches, lin and lmatch, and a three-state FSM: IDLE, GOT_IN, FULL.
REQ-010 Transitions from IDLE:
- in valid and match valid at the same edge -> capture both, go to FULL.
- in valid only -> capture in into lin, go to GOT_IN.
- otherwise -> stay in IDLE.
REQ-011 Transitions from GOT_IN:
- match valid -> capture match into lmatch, go to FULL.
- otherwise -> stay; lin SHALL hold even if in returns to 00.
REQ-012 Transitions from FULL:
- in == 00 and match == 00 at the same edge -> clear lin and lmatch, go to IDLE.
- otherwise -> stay with lin and lmatch frozen; input changes SHALL be ignored.
REQ-013 out SHALL be 00 in IDLE and GOT_IN.
REQ-014 In FULL, out SHALL be computed from the latched tokens:
- out[1] = lin[1] & lmatch[1]
- out[0] = lin[0] | (lin[1] & lmatch[0])
- result: 10 only when lin = 1 and lmatch = 1; 01 in every other valid combination.
REQ-015 out SHALL be registered: it becomes valid at the same rising edge that enters FULL, giving one-edge latency from the edge that samples the last valid token.
REQ-016 out SHALL return to 00 at the same edge that leaves FULL.
REQ-017 out SHALL never be 11.
REQ-018 An illegal token (11) on in or match SHALL never be captured and SHALL never alter state.
REQ-019 A new token SHALL only be accepted after both inputs have returned to 00 following FULL.

Reset
REQ-020 While reset is high, the FSM SHALL be IDLE and lin, lmatch and out SHALL be 00, independent of clk.
REQ-021 Reset asserted in any state, including mid-transaction, SHALL abort the transaction; no partial token survives.
REQ-022 After reset deasserts, the first rising edge SHALL evaluate inputs as from IDLE.

Structure
REQ-023 A shared package SHALL hold:
- token encoding constants TOK_EMPTY = 00, TOK_ZERO = 01, TOK_ONE = 10, TOK_ERR = 11;
- a token-valid helper function;
- the state enum (IDLE, GOT_IN, FULL).
REQ-024 No sub-module is required; the block is a single FSM with two token registers and a registered output.

Verification
REQ-025 The bench SHALL apply stimulus just after the rising edge and check out at the falling edge, skipping the first two vectors after start-up.
REQ-026 The bench SHALL cover these directed scenarios:
- Scenario 1: reset = 1, in = 10, match = 10 -> out = 00 throughout; after release with both inputs 00 -> out stays 00.
- Scenario 2: in = 10, then match = 10 next cycle -> out = 10 one edge after match is sampled; holds until in = match = 00, then out = 00.
- Scenario 3: in = 01 and match = 10 in the same cycle -> out = 01 at the next edge; changing in to 10 while in FULL -> out stays 01.
- Scenario 4: in = 10, then in = 00, then match = 01 -> out = 01 (lin held); only match -> 00 with in still 10 keeps FULL and out = 01.
- Scenario 5: in = 11 or match = 11 from IDLE -> out = 00, state stays IDLE; then in = 10, match = 10 -> out = 10.
- Scenario 6: reset pulsed while out = 10, mid-cycle between edges -> out = 00 immediately; then in = 01, match = 01 -> out = 01.

Source files
------------

// File: rtl/yc_fsm_pkg.sv
// Shared definitions for the dual-rail token matcher: token encodings,
// the validity and result helpers, and the controller state type.
package yc_fsm_pkg;

  localparam logic [1:0] TOK_EMPTY = 2'b00;
  localparam logic [1:0] TOK_ZERO  = 2'b01;
  localparam logic [1:0] TOK_ONE   = 2'b10;
  localparam logic [1:0] TOK_ERR   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT_IN = 2'd1,
    FULL   = 2'd2
  } state_t;

  // Only the two single-rail-high codes carry data; empty and error do not.
  function automatic logic tok_valid(input logic [1:0] tok);
    return (tok == TOK_ZERO) || (tok == TOK_ONE);
  endfunction

  // Dual-rail AND of two valid tokens; never yields TOK_ERR for valid operands.
  function automatic logic [1:0] tok_result(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    r[1] = a[1] & b[1];
    r[0] = a[0] | (a[1] & b[0]);
    return r;
  endfunction

endpackage

// File: rtl/yc_fsm.sv
// Dual-rail token matcher: captures an input token and a match token, then
// presents their dual-rail AND until both inputs return to empty.
module yc_fsm
  import yc_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] in,
  input  logic [1:0] match,
  output logic [1:0] out
);

  state_t     state_reg;
  logic [1:0] lin_reg;
  logic [1:0] lmatch_reg;
  logic [1:0] out_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      lin_reg    <= TOK_EMPTY;
      lmatch_reg <= TOK_EMPTY;
      out_reg    <= TOK_EMPTY;
    end else begin
      case (state_reg)
        IDLE: begin
          // A lone match token is not captured; the input token must lead.
          if (tok_valid(in) && tok_valid(match)) begin
            lin_reg    <= in;
            lmatch_reg <= match;
            out_reg    <= tok_result(in, match);
            state_reg  <= FULL;
          end else if (tok_valid(in)) begin
            lin_reg   <= in;
            state_reg <= GOT_IN;
          end
        end
        GOT_IN: begin
          if (tok_valid(match)) begin
            lmatch_reg <= match;
            out_reg    <= tok_result(lin_reg, match);
            state_reg  <= FULL;
          end
        end
        FULL: begin
          if ((in == TOK_EMPTY) && (match == TOK_EMPTY)) begin
            lin_reg    <= TOK_EMPTY;
            lmatch_reg <= TOK_EMPTY;
            out_reg    <= TOK_EMPTY;
            state_reg  <= IDLE;
          end else begin
            out_reg <= tok_result(lin_reg, lmatch_reg);
          end
        end
        default: begin
          lin_reg    <= TOK_EMPTY;
          lmatch_reg <= TOK_EMPTY;
          out_reg    <= TOK_EMPTY;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign out = out_reg;

endmodule

// File: tb/tb_yc_fsm.sv
// Directed scoreboard bench for yc_fsm: inputs change just after the rising
// edge, results are compared on the falling edge after the sampling edge.
module tb_yc_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] in_s = 2'b00;
  logic [1:0] match_s = 2'b00;
  logic [1:0] out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0] exp;
    int         due;
    bit         chk;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  yc_fsm dut (
    .clk  (clk),
    .reset(reset),
    .in   (in_s),
    .match(match_s),
    .out  (out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare each vector's expected result once its sampling edge has passed.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        checks++;
        if (out !== e.exp) begin
          errors++;
          $display("FAIL %s: out=%b expected=%b (cycle %0d)", e.name, out, e.exp, cyc);
        end else begin
          $display("ok   %s: out=%b", e.name, out);
        end
      end
    end
  end

  task automatic step(input logic [1:0] i, input logic [1:0] m,
                      input logic [1:0] exp, input string name, input bit chk = 1'b1);
    exp_t e;
    in_s    = i;
    match_s = m;
    e.exp  = exp;
    e.due  = cyc + 1;
    e.chk  = chk;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // First two start-up vectors are not checked.
    step(2'b10, 2'b10, 2'b00, "startup0", 1'b0);
    step(2'b10, 2'b10, 2'b00, "startup1", 1'b0);
    step(2'b10, 2'b10, 2'b00, "reset_hold_a");
    step(2'b10, 2'b10, 2'b00, "reset_hold_b");
    reset = 1'b0;
    step(2'b00, 2'b00, 2'b00, "post_reset_a");
    step(2'b00, 2'b00, 2'b00, "post_reset_b");
  endtask

  task automatic test_one_one();
    step(2'b10, 2'b00, 2'b00, "s2_got_in");
    step(2'b10, 2'b10, 2'b10, "s2_full");
    step(2'b10, 2'b10, 2'b10, "s2_hold");
    step(2'b00, 2'b10, 2'b10, "s2_in_empty_only");
    step(2'b00, 2'b00, 2'b00, "s2_release");
    step(2'b00, 2'b00, 2'b00, "s2_idle");
  endtask

  task automatic test_same_cycle();
    step(2'b01, 2'b10, 2'b01, "s3_full");
    step(2'b10, 2'b10, 2'b01, "s3_in_change_ignored");
    step(2'b10, 2'b00, 2'b01, "s3_match_empty_only");
    step(2'b00, 2'b00, 2'b00, "s3_release");
  endtask

  task automatic test_lin_hold();
    step(2'b10, 2'b00, 2'b00, "s4_got_in");
    step(2'b00, 2'b00, 2'b00, "s4_in_empty_hold");
    step(2'b00, 2'b01, 2'b01, "s4_full");
    step(2'b10, 2'b00, 2'b01, "s4_match_empty_only");
    step(2'b00, 2'b00, 2'b00, "s4_release");
    // lin must not be overwritten while waiting for match
    step(2'b01, 2'b00, 2'b00, "s4b_got_in_zero");
    step(2'b10, 2'b00, 2'b00, "s4b_in_changes");
    step(2'b00, 2'b10, 2'b01, "s4b_full_zero");
    step(2'b00, 2'b00, 2'b00, "s4b_release");
  endtask

  task automatic test_illegal();
    step(2'b11, 2'b00, 2'b00, "s5_in_err");
    step(2'b00, 2'b11, 2'b00, "s5_match_err");
    step(2'b11, 2'b11, 2'b00, "s5_both_err");
    step(2'b11, 2'b10, 2'b00, "s5_in_err_match_ok");
    step(2'b00, 2'b10, 2'b00, "s5_still_idle");
    step(2'b10, 2'b10, 2'b10, "s5_full");
    step(2'b00, 2'b00, 2'b00, "s5_release");
    step(2'b10, 2'b00, 2'b00, "s5b_got_in");
    step(2'b00, 2'b11, 2'b00, "s5b_match_err_ignored");
    step(2'b00, 2'b01, 2'b01, "s5b_full");
    step(2'b00, 2'b00, 2'b00, "s5b_release");
  endtask

  task automatic test_async_reset();
    step(2'b10, 2'b10, 2'b10, "s6_full");
    step(2'b10, 2'b10, 2'b10, "s6_hold");
    @(negedge clk);
    #2;
    in_s    = 2'b00;
    match_s = 2'b00;
    reset   = 1'b1;
    #1;
    checks++;
    if (out !== 2'b00) begin
      errors++;
      $display("FAIL s6_async_clear: out=%b expected=00", out);
    end else begin
      $display("ok   s6_async_clear: out=%b", out);
    end
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(2'b01, 2'b01, 2'b01, "s6_after_reset");
    step(2'b00, 2'b00, 2'b00, "s6_release");
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_one_one();
    test_same_cycle();
    test_lin_hold();
    test_illegal();
    test_async_reset();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
